// File: rtl/instr_fetch.sv
// instr_fetch: instruction fetch sequencer for the byte-wide decoder.
// Walks a byte-addressed program counter over a req/ack memory port and presents
// one instruction byte per issue slot, qualified by force_nop. Opcode 8'h80 is
// fetched together with its trailing immediate byte.
// Optional feature macro: CHOC_FETCH_JUMP_WAIT_EN. When defined, an issued jump
// (instr[7:6] == 2'b11) parks fetch until execute resolves it. When undefined,
// fetch runs on past jumps and relies on the taken-resolve flush to redirect.
module instr_fetch #(
    parameter int unsigned          PC_WIDTH = 8,
    parameter logic [PC_WIDTH-1:0]  RESET_PC = '0
) (
    input  logic                clk,
    input  logic                rst,
    output logic                mem_req,
    output logic [PC_WIDTH-1:0] mem_addr,
    input  logic                mem_ack,
    input  logic [7:0]          mem_data,
    input  logic                stall,
    input  logic                resolve_valid,
    input  logic                resolve_taken,
    input  logic [PC_WIDTH-1:0] resolve_pc,
    output logic [7:0]          instr,
    output logic                force_nop,
    output logic [7:0]          imm,
    output logic                imm_valid,
    output logic [PC_WIDTH-1:0] issue_pc
);

    localparam logic [7:0] OpLoadNext = 8'h80;

`ifdef CHOC_FETCH_JUMP_WAIT_EN
    typedef enum logic [2:0] {StFetch, StFetchImm, StIssue, StDrain, StWaitResolve} state_e;
`else
    typedef enum logic [2:0] {StFetch, StFetchImm, StIssue, StDrain} state_e;
`endif

    state_e              state_q, state_d;
    logic [PC_WIDTH-1:0] fetch_pc_q, fetch_pc_d;
    logic                discard_q, discard_d;
    logic                mem_req_q, mem_req_d;
    logic [PC_WIDTH-1:0] mem_addr_q, mem_addr_d;
    logic [7:0]          instr_q, instr_d;
    logic                force_nop_q, force_nop_d;
    logic [7:0]          imm_q, imm_d;
    logic                imm_valid_q, imm_valid_d;
    logic [PC_WIDTH-1:0] issue_pc_q, issue_pc_d;

    logic ack;
    logic flush;

    // An ack only counts against a request that is actually on the bus.
    assign ack   = mem_ack & mem_req_q;
    assign flush = resolve_valid & resolve_taken;

`ifdef CHOC_FETCH_JUMP_WAIT_EN
    logic is_jump;
    assign is_jump = (instr_q[7:6] == 2'b11);
`endif

    // Next-state and datapath updates; a taken resolve outranks ack and issue.
    always_comb begin
        state_d     = state_q;
        fetch_pc_d  = fetch_pc_q;
        discard_d   = discard_q;
        instr_d     = instr_q;
        imm_d       = imm_q;
        imm_valid_d = imm_valid_q;
        issue_pc_d  = issue_pc_q;

        case (state_q)
            StFetch, StFetchImm: begin
                if (flush) begin
                    fetch_pc_d = resolve_pc;
                    // An unacked request cannot be withdrawn: wait it out in drain.
                    if (mem_req_q && !mem_ack) begin
                        discard_d = 1'b1;
                        state_d   = StDrain;
                    end else begin
                        state_d = StFetch;
                    end
                end else if (ack) begin
                    fetch_pc_d = fetch_pc_q + PC_WIDTH'(1);
                    if (state_q == StFetchImm) begin
                        imm_d       = mem_data;
                        imm_valid_d = 1'b1;
                        instr_d     = OpLoadNext;
                        state_d     = StIssue;
                    end else if (mem_data == OpLoadNext) begin
                        // Opcode address is latched now; the opcode itself is implied.
                        issue_pc_d = fetch_pc_q;
                        state_d    = StFetchImm;
                    end else begin
                        instr_d    = mem_data;
                        issue_pc_d = fetch_pc_q;
                        state_d    = StIssue;
                    end
                end
            end

            StIssue: begin
                if (flush) begin
                    fetch_pc_d  = resolve_pc;
                    imm_valid_d = 1'b0;
                    state_d     = StFetch;
                end else if (!stall) begin
                    imm_valid_d = 1'b0;
`ifdef CHOC_FETCH_JUMP_WAIT_EN
                    state_d     = is_jump ? StWaitResolve : StFetch;
`else
                    state_d     = StFetch;
`endif
                end
            end

`ifdef CHOC_FETCH_JUMP_WAIT_EN
            StWaitResolve: begin
                if (resolve_valid) begin
                    if (resolve_taken) begin
                        fetch_pc_d = resolve_pc;
                    end
                    state_d = StFetch;
                end
            end
`endif

            StDrain: begin
                if (flush) begin
                    fetch_pc_d = resolve_pc;
                end
                if (ack) begin
                    discard_d = 1'b0;
                    state_d   = StFetch;
                end
            end

            default: begin
                state_d = StFetch;
            end
        endcase
    end

    // Registered bus and qualifier outputs follow the state being entered.
    always_comb begin
        mem_req_d   = (state_d == StFetch) || (state_d == StFetchImm) || (state_d == StDrain);
        mem_addr_d  = (state_d == StDrain) ? mem_addr_q : fetch_pc_d;
        force_nop_d = (state_d != StIssue);
    end

    // State and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StFetch;
            fetch_pc_q  <= RESET_PC;
            discard_q   <= 1'b0;
            mem_req_q   <= 1'b0;
            mem_addr_q  <= RESET_PC;
            instr_q     <= 8'h00;
            force_nop_q <= 1'b1;
            imm_q       <= 8'h00;
            imm_valid_q <= 1'b0;
            issue_pc_q  <= RESET_PC;
        end else begin
            state_q     <= state_d;
            fetch_pc_q  <= fetch_pc_d;
            discard_q   <= discard_d;
            mem_req_q   <= mem_req_d;
            mem_addr_q  <= mem_addr_d;
            instr_q     <= instr_d;
            force_nop_q <= force_nop_d;
            imm_q       <= imm_d;
            imm_valid_q <= imm_valid_d;
            issue_pc_q  <= issue_pc_d;
        end
    end

    assign mem_req   = mem_req_q;
    assign mem_addr  = mem_addr_q;
    assign instr     = instr_q;
    assign force_nop = force_nop_q;
    assign imm       = imm_q;
    assign imm_valid = imm_valid_q;
    assign issue_pc  = issue_pc_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: directed sequences for the listed scenarios, then a
// randomized run checked against a program-walk model of the issued stream.
module tb_instr_fetch;

    logic       clk;
    logic       rst;
    logic       mem_req;
    logic [7:0] mem_addr;
    logic       mem_ack;
    logic [7:0] mem_data;
    logic       stall;
    logic       resolve_valid;
    logic       resolve_taken;
    logic [7:0] resolve_pc;
    logic [7:0] instr;
    logic       force_nop;
    logic [7:0] imm;
    logic       imm_valid;
    logic [7:0] issue_pc;

    logic [7:0] mem [256];
    int         ack_mode;   // 0 manual, 1 zero-wait, 2 random
    logic       manual_ack;
    int         n_checks;
    int         n_errors;

    instr_fetch #(
        .PC_WIDTH (8),
        .RESET_PC (8'h00)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .mem_req       (mem_req),
        .mem_addr      (mem_addr),
        .mem_ack       (mem_ack),
        .mem_data      (mem_data),
        .stall         (stall),
        .resolve_valid (resolve_valid),
        .resolve_taken (resolve_taken),
        .resolve_pc    (resolve_pc),
        .instr         (instr),
        .force_nop     (force_nop),
        .imm           (imm),
        .imm_valid     (imm_valid),
        .issue_pc      (issue_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory responder, updated mid-cycle so the DUT sees stable inputs.
    always @(negedge clk) begin
        mem_data = mem[mem_addr];
        case (ack_mode)
            0:       mem_ack = manual_ack & mem_req;
            1:       mem_ack = mem_req;
            default: mem_ack = mem_req && ($urandom_range(0, 2) != 0);
        endcase
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_values();
        check("rst_req", mem_req, 0);
        check("rst_addr", mem_addr, 8'h00);
        check("rst_instr", instr, 8'h00);
        check("rst_nop", force_nop, 1);
        check("rst_imm", imm, 8'h00);
        check("rst_immv", imm_valid, 0);
        check("rst_ipc", issue_pc, 8'h00);
    endtask

    // Starts in the FETCH cycle for pc (zero-wait memory); ends in the cycle
    // after the issued byte was consumed.
    task automatic issue_check(input logic [7:0] pc, input logic [7:0] op, input logic [7:0] ival);
        logic [7:0] nxt;
        nxt = pc + 8'd1;
        check("fetch_req", mem_req, 1);
        check("fetch_addr", mem_addr, pc);
        check("fetch_nop", force_nop, 1);
        check("fetch_immv", imm_valid, 0);
        step();
        if (op == 8'h80) begin
            check("fimm_req", mem_req, 1);
            check("fimm_addr", mem_addr, nxt);
            check("fimm_nop", force_nop, 1);
            step();
        end
        check("issue_nop", force_nop, 0);
        check("issue_instr", instr, op);
        check("issue_pc", issue_pc, pc);
        check("issue_req", mem_req, 0);
        check("issue_immv", imm_valid, (op == 8'h80));
        if (op == 8'h80) check("issue_imm", imm, ival);
        stall = 1'b0;
        step();
    endtask

`ifdef CHOC_FETCH_JUMP_WAIT_EN
    task automatic wait_then_resolve(input logic taken, input logic [7:0] target);
        for (int i = 0; i < 4; i++) begin
            check("wait_req", mem_req, 0);
            check("wait_nop", force_nop, 1);
            if (i == 3) begin
                resolve_valid = 1'b1;
                resolve_taken = taken;
                resolve_pc    = target;
            end
            step();
        end
        resolve_valid = 1'b0;
        resolve_taken = 1'b0;
    endtask
`endif

    initial begin
        logic [7:0] flush_addr;
        logic [7:0] model_pc;
        logic [7:0] op;
        logic       prev_req;
        logic [7:0] prev_addr;
        int         issues;

        n_checks = 0;
        n_errors = 0;
        rst = 1'b0;
        stall = 1'b0;
        resolve_valid = 1'b0;
        resolve_taken = 1'b0;
        resolve_pc = 8'h00;
        manual_ack = 1'b0;
        ack_mode = 1;
        mem_ack = 1'b0;
        mem_data = 8'h00;
        for (int i = 0; i < 256; i++) mem[i] = 8'h01;
        mem[0] = 8'h12; mem[1] = 8'h34; mem[2] = 8'h56; mem[3] = 8'hC0;
        mem[4] = 8'h11; mem[5] = 8'h80; mem[6] = 8'hAB; mem[7] = 8'hC2;
        mem[8] = 8'h23; mem[9] = 8'h77;
        mem[8'h20] = 8'h23; mem[8'h21] = 8'h77;
        mem[8'h40] = 8'h44; mem[8'hFF] = 8'h80;

        // Asynchronous reset takes effect before any clock edge.
        #2 rst = 1'b1;
        #1 check_reset_values();
        step();
        step();
        rst = 1'b0;
        step();

        // 12 at 0 with a 3-cycle stall, then 34, 56.
        check("fetch0_req", mem_req, 1);
        check("fetch0_addr", mem_addr, 8'h00);
        step();
        check("i12_nop", force_nop, 0);
        check("i12_instr", instr, 8'h12);
        check("i12_pc", issue_pc, 8'h00);
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check("stall_nop", force_nop, 0);
            check("stall_instr", instr, 8'h12);
            check("stall_pc", issue_pc, 8'h00);
            check("stall_req", mem_req, 0);
        end
        stall = 1'b0;
        step();
        issue_check(8'h01, 8'h34, 8'h00);
        issue_check(8'h02, 8'h56, 8'h00);

`ifdef CHOC_FETCH_JUMP_WAIT_EN
        issue_check(8'h03, 8'hC0, 8'h00);
        wait_then_resolve(1'b0, 8'h99);
        issue_check(8'h04, 8'h11, 8'h00);
        issue_check(8'h05, 8'h80, 8'hAB);
        issue_check(8'h07, 8'hC2, 8'h00);
        wait_then_resolve(1'b1, 8'h20);
        issue_check(8'h20, 8'h23, 8'h00);
        flush_addr = 8'h21;
`else
        issue_check(8'h03, 8'hC0, 8'h00);
        issue_check(8'h04, 8'h11, 8'h00);
        issue_check(8'h05, 8'h80, 8'hAB);
        issue_check(8'h07, 8'hC2, 8'h00);
        issue_check(8'h08, 8'h23, 8'h00);
        flush_addr = 8'h09;
`endif

        // Taken resolve while the request is outstanding; ack arrives 2 cycles later.
        ack_mode = 0;
        check("flush_req", mem_req, 1);
        check("flush_addr", mem_addr, flush_addr);
        resolve_valid = 1'b1;
        resolve_taken = 1'b1;
        resolve_pc = 8'h40;
        step();
        resolve_valid = 1'b0;
        resolve_taken = 1'b0;
        for (int i = 0; i < 2; i++) begin
            check("drain_req", mem_req, 1);
            check("drain_addr", mem_addr, flush_addr);
            check("drain_nop", force_nop, 1);
            if (i == 1) manual_ack = 1'b1;
            step();
        end
        manual_ack = 1'b0;
        ack_mode = 1;
        issue_check(8'h40, 8'h44, 8'h00);

        // Redirect to FF (flush coinciding with an ack), 80 at FF wraps to 0.
        mem[0] = 8'h01;
        resolve_valid = 1'b1;
        resolve_taken = 1'b1;
        resolve_pc = 8'hFF;
        step();
        resolve_valid = 1'b0;
        resolve_taken = 1'b0;
        issue_check(8'hFF, 8'h80, 8'h01);
        check("wrap_next_req", mem_req, 1);
        check("wrap_next_addr", mem_addr, 8'h01);

        // Reset pulse mid-FETCH: outputs return at once.
        rst = 1'b1;
        #1 check_reset_values();
        for (int i = 0; i < 256; i++) begin
            mem[i] = ($urandom_range(0, 7) == 0) ? 8'h80 : 8'($urandom);
        end
        ack_mode = 2;
        #1 rst = 1'b0;

        // Random run: the consumed stream must follow the program walk from pc,
        // restarting at resolve_pc on every taken resolve.
        model_pc = 8'h00;
        prev_req = 1'b0;
        prev_addr = 8'h00;
        issues = 0;
        step();
        for (int cyc = 0; cyc < 4000; cyc++) begin
            if (prev_req && !mem_ack) begin
                check("hold_req", mem_req, 1);
                check("hold_addr", mem_addr, prev_addr);
            end
            if (mem_req) check("req_nop", force_nop, 1);
            prev_req = mem_req;
            prev_addr = mem_addr;

            stall = ($urandom_range(0, 3) == 0);
            resolve_valid = ($urandom_range(0, 9) == 0);
            resolve_taken = resolve_valid && ($urandom_range(0, 1) == 1);
            resolve_pc = 8'($urandom);

            if (resolve_valid && resolve_taken) begin
                model_pc = resolve_pc;
            end else if (!force_nop && !stall) begin
                op = mem[model_pc];
                check("rnd_pc", issue_pc, model_pc);
                check("rnd_instr", instr, op);
                check("rnd_immv", imm_valid, (op == 8'h80));
                if (op == 8'h80) begin
                    check("rnd_imm", imm, mem[8'(model_pc + 8'd1)]);
                    model_pc = model_pc + 8'd2;
                end else begin
                    model_pc = model_pc + 8'd1;
                end
                issues++;
            end
            step();
        end
        resolve_valid = 1'b0;
        resolve_taken = 1'b0;
        stall = 1'b0;
        check("rnd_progress", (issues > 100), 1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/instr_fetch.md
# instr_fetch

Instruction fetch sequencer feeding the byte-wide instruction decoder. It walks a program counter through byte-addressed instruction memory over a request/acknowledge handshake and presents one instruction byte per issue slot with a `force_nop` qualifier. The load-next opcode 8'h80 is fetched together with its trailing immediate byte. Jumps (`instr[7:6] == 2'b11`) are held until execute resolves them.

## Interface
- `PC_WIDTH`, 8, width of fetch and issue program counters
- `RESET_PC`, 0, first fetch address after reset

- `clk`  in  1  clock, all state on rising edge
- `rst`  in  1  asynchronous, active-high reset
- `mem_req`  out  1  memory read request, registered
- `mem_addr`  out  PC_WIDTH  byte address of request, registered
- `mem_ack`  in  1  read data valid this cycle; accepted only while `mem_req`=1
- `mem_data`  in  8  read byte, sampled when `mem_ack`=1
- `stall`  in  1  decoder/execute cannot accept the issued byte
- `resolve_valid`  in  1  single-cycle jump resolution pulse
- `resolve_taken`  in  1  with `resolve_valid`: 1 = redirect, 0 = fall through
- `resolve_pc`  in  PC_WIDTH  redirect target
- `instr`  out  8  instruction byte to decoder
- `force_nop`  out  1  1 = `instr` is not a real issue; decoder treats as NOP
- `imm`  out  8  immediate byte following 8'h80
- `imm_valid`  out  1  `imm` qualifies current `instr` (only with `instr`=8'h80)
- `issue_pc`  out  PC_WIDTH  address of the byte on `instr`

## Operation
- Reset values: `mem_req`=0, `mem_addr`=RESET_PC, `instr`=8'h00, `force_nop`=1, `imm`=0, `imm_valid`=0, `issue_pc`=RESET_PC, fetch_pc=RESET_PC, state FETCH, discard=0.
- FETCH: `mem_req`=1, `mem_addr`=fetch_pc. On ack: fetch_pc+1. If data=8'h80, hold it and go FETCH_IMM; otherwise load `instr`, set `issue_pc`, and go ISSUE.
- FETCH_IMM: request fetch_pc. On ack: `imm`<=data, `imm_valid`<=1, `instr`<=8'h80, fetch_pc+1, go ISSUE.
- ISSUE: `force_nop`=0. While `stall`=1, hold every output. When `stall`=0, the byte is consumed. If it is a jump, go WAIT_RESOLVE; otherwise go FETCH. Clear `imm_valid` and assert `force_nop` on leaving.
- WAIT_RESOLVE: no request, `force_nop`=1.
  - `resolve_valid`&`resolve_taken`: fetch_pc<=`resolve_pc`, go FETCH.
  - `resolve_valid`&!`resolve_taken`: go FETCH at the unchanged fetch_pc.
- Taken resolve outside WAIT_RESOLVE acts as a flush and has priority over ack and issue:
  - fetch_pc<=`resolve_pc`.
  - In ISSUE, the byte is dropped (`force_nop`=1 next cycle) and state goes FETCH.
  - In FETCH/FETCH_IMM with no ack this cycle: set discard and go DRAIN.
  - In FETCH/FETCH_IMM with an ack this cycle: drop the data and go FETCH.
- DRAIN: hold `mem_req`=1 with the old address until ack, drop the data, clear discard, go FETCH. A new taken resolve here updates fetch_pc only.
- Not-taken resolve outside WAIT_RESOLVE is ignored.
- A request is never withdrawn before its ack; `mem_addr` is stable while `mem_req`=1.
- PC arithmetic is modulo 2^PC_WIDTH; address 2^PC_WIDTH-1 wraps to 0, including the immediate of an 8'h80 at the top address.

## Timing
- Ack may arrive in the first cycle `mem_req` is high. Minimum is then 2 cycles per plain instruction (FETCH, ISSUE) and 3 for 8'h80.
- Data accepted on the ack edge appears on `instr` the following cycle.
- A taken resolve in cycle N puts `mem_addr`=`resolve_pc` with `mem_req`=1 in cycle N+1 (N+1 after drain completes if a request was outstanding).
- `force_nop`=1 in every cycle not in ISSUE.

## Configuration
- `CHOC_FETCH_JUMP_WAIT_EN` defined: behaviour above; a jump parks fetch in WAIT_RESOLVE.
- Undefined: WAIT_RESOLVE is not built. After a jump the sequencer continues fetching fall-through, relies on the taken-resolve flush/drain path to redirect, and ignores not-taken resolves.

## Test plan
- Reset, then memory at 0..2 = 8'h12, 8'h34, 8'h56 with zero-wait ack. Required: `instr` 12, 34, 56 with `force_nop`=0 on every second cycle, and `issue_pc` 0, 1, 2.
- 8'h80 at 5, 8'hAB at 6. Required: one ISSUE cycle with `instr`=80, `imm`=AB, `imm_valid`=1, `issue_pc`=5; next fetch address is 7.
- `stall`=1 for 3 cycles during ISSUE of 8'h12. Required: outputs frozen for 3 cycles, no `mem_req`, then fetch continues at the next address.
- Jump 8'hC0 at 3 (wait enabled), resolve taken to 8'h20 after 4 cycles. Required: `mem_req`=0 while waiting, then `mem_addr`=20. Repeat with not-taken: `mem_addr`=4.
- Taken resolve to 8'h40 while a request to 9 is outstanding, ack 2 cycles later with 8'h77. Required: 77 never issued; next `mem_addr`=40.
- fetch_pc=8'hFF holding 8'h80, address 0 holding 8'h01, then async `rst` pulsed mid-FETCH. Required: `imm`=01 with next fetch at 1; after the reset pulse, all outputs return to reset values immediately.
